// File: rtl/network_injection_arbiter_if.sv
// Bundle between the requesters/router and the injection arbiter.
// The request path is a valid/ready handshake. A requester raises
// req_valid[i] with its fields stable, and the transfer happens on the
// rising edge where req_valid[i] and req_ready[i] are both 1.
// req_ready[i] depends only on the slot state and never on req_valid[i].
// The router side is a one-cycle strobe that has no back-pressure.
interface network_injection_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int DEST_WIDTH     = 4,
    parameter int NET_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 6
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_read;
    logic [NUM_REQ-1:0]                req_write;
    logic [NUM_REQ*DEST_WIDTH-1:0]     req_dest;
    logic [NUM_REQ*NET_ADDR_WIDTH-1:0] req_src;
    logic [NUM_REQ*DATA_WIDTH-1:0]     req_data;
    logic                              resp_valid;
    logic [DEST_WIDTH-1:0]             destinationAddressOut;
    logic [NET_ADDR_WIDTH-1:0]         requesterAddressOut;
    logic                              readOut;
    logic                              writeOut;
    logic [DATA_WIDTH-1:0]             dataOut;
    logic [ID_W-1:0]                   grant_id;
    logic [3:0]                        outstanding;
    logic                              drop_err;
    logic [1:0]                        fsm_state;

    // The requester and router side, which drives requests and responses.
    modport master (
        output req_valid, req_read, req_write, req_dest, req_src, req_data, resp_valid,
        input  req_ready, destinationAddressOut, requesterAddressOut, readOut, writeOut,
        input  dataOut, grant_id, outstanding, drop_err, fsm_state
    );

    // The arbiter side.
    modport slave (
        input  req_valid, req_read, req_write, req_dest, req_src, req_data, resp_valid,
        output req_ready, destinationAddressOut, requesterAddressOut, readOut, writeOut,
        output dataOut, grant_id, outstanding, drop_err, fsm_state
    );
endinterface

// File: rtl/network_injection_arbiter.sv
// Injection arbiter. NUM_REQ requesters share one router input port.
// Each requester has a one-entry slot. A round-robin FSM sends one packet
// per INJECT cycle and then holds a programmable idle gap. Reads are
// throttled by an outstanding-read counter, and read responses decrement it.
module network_injection_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DEST_WIDTH      = 4,
    parameter int NET_ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH      = 6,
    parameter int INJECT_GAP      = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic clk,
    input logic reset,
    network_injection_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_INJECT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // Slot storage
    logic [NUM_REQ-1:0]        slot_full;
    logic [NUM_REQ-1:0]        slot_read;
    logic [DEST_WIDTH-1:0]     slot_dest [NUM_REQ];
    logic [NET_ADDR_WIDTH-1:0] slot_src  [NUM_REQ];
    logic [DATA_WIDTH-1:0]     slot_data [NUM_REQ];

    // FSM and output registers
    logic [1:0]                state;
    logic [3:0]                gap_cnt;
    logic [ID_W-1:0]           rr_ptr;
    logic [ID_W-1:0]           grant_id;
    logic                      read_out;
    logic                      write_out;
    logic [DEST_WIDTH-1:0]     dest_out;
    logic [NET_ADDR_WIDTH-1:0] src_out;
    logic [DATA_WIDTH-1:0]     data_out;
    logic [3:0]                outstanding;
    logic                      drop_err;

    // Combinational helpers
    logic [NUM_REQ-1:0] legal;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] eligible;
    logic               read_room;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W-1:0]    scan_id;
    int                 scan_pos;
    logic               inject_read;

    // A request is legal when exactly one of read or write is set.
    // A blocked read stays full but is not eligible.
    always_comb begin
        read_room = (outstanding < 4'(MAX_OUTSTANDING));
        legal     = bus.req_read ^ bus.req_write;
        accept    = bus.req_valid & ~slot_full;
        eligible  = slot_full & (~slot_read | {NUM_REQ{read_room}});
    end

    // Round-robin search: pick the first eligible slot at or after rr_ptr, with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_pos   = 0;
        scan_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_pos = int'(rr_ptr) + i;
            if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
            scan_id = ID_W'(scan_pos);
            if (!pick_found && eligible[scan_id]) begin
                pick_found = 1'b1;
                pick_idx   = scan_id;
            end
        end
    end

    assign inject_read = (state == ST_INJECT) && read_out;

    // Slot fill and clear. A legal request fills its slot. An illegal request is accepted but discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full <= '0;
            slot_read <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_dest[i] <= '0;
                slot_src[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state == ST_INJECT && grant_id == ID_W'(i)) begin
                    slot_full[i] <= 1'b0;
                end else if (accept[i] && legal[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_read[i] <= bus.req_read[i];
                    slot_dest[i] <= bus.req_dest[i*DEST_WIDTH +: DEST_WIDTH];
                    slot_src[i]  <= bus.req_src[i*NET_ADDR_WIDTH +: NET_ADDR_WIDTH];
                    slot_data[i] <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Injection FSM. The router outputs are registered and are nonzero only during INJECT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            read_out  <= 1'b0;
            write_out <= 1'b0;
            dest_out  <= '0;
            src_out   <= '0;
            data_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state     <= ST_INJECT;
                        grant_id  <= pick_idx;
                        read_out  <= slot_read[pick_idx];
                        write_out <= ~slot_read[pick_idx];
                        dest_out  <= slot_dest[pick_idx];
                        src_out   <= slot_src[pick_idx];
                        data_out  <= slot_data[pick_idx];
                    end
                end
                ST_INJECT: begin
                    rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    grant_id  <= '0;
                    read_out  <= 1'b0;
                    write_out <= 1'b0;
                    dest_out  <= '0;
                    src_out   <= '0;
                    data_out  <= '0;
                    if (INJECT_GAP > 0) begin
                        state   <= ST_GAP;
                        gap_cnt <= 4'(INJECT_GAP - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                    state     <= ST_IDLE;
                    grant_id  <= '0;
                    read_out  <= 1'b0;
                    write_out <= 1'b0;
                    dest_out  <= '0;
                    src_out   <= '0;
                    data_out  <= '0;
                end
            endcase
        end
    end

    // Outstanding reads. A response in the same cycle as a read exit cancels it.
    // A response with nothing outstanding is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else if (inject_read && !bus.resp_valid) begin
            outstanding <= outstanding + 4'd1;
        end else if (!inject_read && bus.resp_valid && outstanding != 4'd0) begin
            outstanding <= outstanding - 4'd1;
        end
    end

    // One-cycle pulse when an illegal request is accepted and dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_err <= 1'b0;
        else        drop_err <= |(accept & ~legal);
    end

    assign bus.req_ready             = ~slot_full;
    assign bus.destinationAddressOut = dest_out;
    assign bus.requesterAddressOut   = src_out;
    assign bus.readOut               = read_out;
    assign bus.writeOut              = write_out;
    assign bus.dataOut               = data_out;
    assign bus.grant_id              = grant_id;
    assign bus.outstanding           = outstanding;
    assign bus.drop_err              = drop_err;
    assign bus.fsm_state             = state;
endmodule

// File: tb/tb_network_injection_arbiter.sv
// Directed bench for network_injection_arbiter, with NUM_REQ=4, INJECT_GAP=1 and MAX_OUTSTANDING=2.
module tb_network_injection_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    network_injection_arbiter_if #(
        .NUM_REQ(4), .DEST_WIDTH(4), .NET_ADDR_WIDTH(4), .DATA_WIDTH(6)
    ) bus ();

    network_injection_arbiter #(
        .NUM_REQ(4), .DEST_WIDTH(4), .NET_ADDR_WIDTH(4), .DATA_WIDTH(6),
        .INJECT_GAP(1), .MAX_OUTSTANDING(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Driver tasks
    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [3:0] d, input logic [3:0] s, input logic [5:0] dat);
        bus.req_valid[i]       = 1'b1;
        bus.req_read[i]        = rd;
        bus.req_write[i]       = wr;
        bus.req_dest[i*4 +: 4] = d;
        bus.req_src[i*4 +: 4]  = s;
        bus.req_data[i*6 +: 6] = dat;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.req_read   = '0;
        bus.req_write  = 4'b1111;
        bus.req_dest   = '0;
        bus.req_src    = '0;
        bus.req_data   = '0;
        bus.resp_valid = 1'b0;

        // Reset held for two cycles while every requester is valid
        tick();
        tick();
        chk("rst_ready", bus.req_ready, 4'hf);
        chk("rst_write", bus.writeOut, 0);
        chk("rst_read", bus.readOut, 0);
        chk("rst_data", bus.dataOut, 0);
        chk("rst_dest", bus.destinationAddressOut, 0);
        chk("rst_src", bus.requesterAddressOut, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_outst", bus.outstanding, 0);
        chk("rst_drop", bus.drop_err, 0);
        bus.req_valid = '0;
        bus.req_write = '0;
        reset = 1'b1;
        tick();
        chk("post_rst_write", bus.writeOut, 0);

        // Single write from requester 0
        set_req(0, 1'b0, 1'b1, 4'd10, 4'd0, 6'd42);
        tick();
        clear_req();
        chk("sw_ready_full", bus.req_ready, 4'b1110);
        chk("sw_idle_write", bus.writeOut, 0);
        tick();
        chk("sw_write", bus.writeOut, 1);
        chk("sw_read", bus.readOut, 0);
        chk("sw_dest", bus.destinationAddressOut, 10);
        chk("sw_data", bus.dataOut, 42);
        chk("sw_src", bus.requesterAddressOut, 0);
        chk("sw_grant", bus.grant_id, 0);
        tick();
        chk("sw_gap_write", bus.writeOut, 0);
        chk("sw_gap_dest", bus.destinationAddressOut, 0);
        chk("sw_gap_data", bus.dataOut, 0);
        chk("sw_gap_ready", bus.req_ready, 4'hf);

        // Round robin: four writes load together and inject in the order 0,1,2,3, one every 3 cycles
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 4'(i + 1), 4'(i), 6'(10 + i));
        tick();
        clear_req();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_write", bus.writeOut, 1);
            chk("rr_grant", bus.grant_id, 32'(k));
            chk("rr_data", bus.dataOut, 32'(10 + k));
            chk("rr_dest", bus.destinationAddressOut, 32'(k + 1));
            chk("rr_src", bus.requesterAddressOut, 32'(k));
            tick();
            chk("rr_gap_write", bus.writeOut, 0);
            tick();
            chk("rr_idle_write", bus.writeOut, 0);
            chk("rr_idle_grant", bus.grant_id, 0);
        end

        // Read throttle at MAX_OUTSTANDING=2
        set_req(0, 1'b1, 1'b0, 4'd5, 4'd0, 6'd0);
        set_req(1, 1'b1, 1'b0, 4'd6, 4'd1, 6'd0);
        set_req(2, 1'b1, 1'b0, 4'd7, 4'd2, 6'd0);
        tick();
        clear_req();
        tick();
        chk("rt_read0", bus.readOut, 1);
        chk("rt_grant0", bus.grant_id, 0);
        chk("rt_dest0", bus.destinationAddressOut, 5);
        tick();
        chk("rt_outst1", bus.outstanding, 1);
        chk("rt_gap_read", bus.readOut, 0);
        tick();
        tick();
        chk("rt_read1", bus.readOut, 1);
        chk("rt_grant1", bus.grant_id, 1);
        chk("rt_dest1", bus.destinationAddressOut, 6);
        tick();
        chk("rt_outst2", bus.outstanding, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rt_held_read", bus.readOut, 0);
            chk("rt_held_outst", bus.outstanding, 2);
            chk("rt_held_ready", bus.req_ready, 4'b1011);
        end
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        chk("rt_resp_outst", bus.outstanding, 1);
        chk("rt_resp_read", bus.readOut, 0);
        tick();
        chk("rt_read2", bus.readOut, 1);
        chk("rt_grant2", bus.grant_id, 2);
        chk("rt_dest2", bus.destinationAddressOut, 7);
        tick();
        chk("rt_outst_back", bus.outstanding, 2);
        chk("rt_gap_read2", bus.readOut, 0);

        // Mixed: a read blocked at the limit, with a write queued on requester 1
        set_req(0, 1'b1, 1'b0, 4'd3, 4'd0, 6'd0);
        set_req(1, 1'b0, 1'b1, 4'd9, 4'd1, 6'd33);
        tick();
        clear_req();
        chk("mx_ready", bus.req_ready, 4'b1100);
        chk("mx_idle_write", bus.writeOut, 0);
        tick();
        chk("mx_write", bus.writeOut, 1);
        chk("mx_read", bus.readOut, 0);
        chk("mx_grant", bus.grant_id, 1);
        chk("mx_data", bus.dataOut, 33);
        tick();
        tick();
        chk("mx_blocked_read", bus.readOut, 0);
        chk("mx_blocked_ready", bus.req_ready, 4'b1110);
        chk("mx_blocked_outst", bus.outstanding, 2);
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        chk("mx_resp_outst", bus.outstanding, 1);
        chk("mx_resp_read", bus.readOut, 0);
        tick();
        chk("mx_read_inj", bus.readOut, 1);
        chk("mx_read_grant", bus.grant_id, 0);
        chk("mx_read_dest", bus.destinationAddressOut, 3);
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        chk("mx_simul_outst", bus.outstanding, 1);
        chk("mx_after_read", bus.readOut, 0);
        chk("mx_after_ready", bus.req_ready, 4'hf);

        // Illegal requests: one with both read and write set, one with neither set
        set_req(3, 1'b1, 1'b1, 4'd1, 4'd3, 6'd1);
        tick();
        clear_req();
        chk("il_both_drop", bus.drop_err, 1);
        chk("il_both_ready", bus.req_ready, 4'hf);
        chk("il_both_read", bus.readOut, 0);
        chk("il_both_write", bus.writeOut, 0);
        tick();
        chk("il_both_drop_end", bus.drop_err, 0);
        chk("il_both_no_write", bus.writeOut, 0);
        chk("il_both_no_read", bus.readOut, 0);
        set_req(2, 1'b0, 1'b0, 4'd2, 4'd2, 6'd2);
        tick();
        clear_req();
        chk("il_none_drop", bus.drop_err, 1);
        chk("il_none_ready", bus.req_ready, 4'hf);
        tick();
        chk("il_none_drop_end", bus.drop_err, 0);
        chk("il_none_no_write", bus.writeOut, 0);

        // Reset asserted in the middle of an INJECT cycle
        set_req(2, 1'b0, 1'b1, 4'd12, 4'd2, 6'd7);
        tick();
        clear_req();
        tick();
        chk("ar_write", bus.writeOut, 1);
        chk("ar_grant", bus.grant_id, 2);
        chk("ar_outst_pre", bus.outstanding, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_async_write", bus.writeOut, 0);
        chk("ar_async_grant", bus.grant_id, 0);
        chk("ar_async_dest", bus.destinationAddressOut, 0);
        chk("ar_async_data", bus.dataOut, 0);
        chk("ar_async_outst", bus.outstanding, 0);
        chk("ar_async_ready", bus.req_ready, 4'hf);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_after_ready", bus.req_ready, 4'hf);
        chk("ar_after_write", bus.writeOut, 0);
        chk("ar_after_drop", bus.drop_err, 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
